// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-ported data memory between the two
// issue lanes. Lane 0 (older) has fixed priority. One access is granted per
// cycle, and one tagged response is returned per access. A RUN/HOLD FSM
// handles response back-pressure.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_*0 / req_*1          lane requests (valid/ready, isld, isst, addr, wdata, tag)
//   mem_en/we/addr/wdata     memory port, issued in the grant cycle
//   mem_rdata                read data, valid the cycle after a read strobe
//   rsp_*                    writeback response (valid/ready, lane, tag, isst, err, data)
//   conflict_cnt             saturating count of RUN cycles with both lanes valid
module dmem_port_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned TAG_W  = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid0,
  input  logic                       req_valid1,
  output logic                       req_ready0,
  output logic                       req_ready1,
  input  logic                       req_isld0,
  input  logic                       req_isld1,
  input  logic                       req_isst0,
  input  logic                       req_isst1,
  input  logic [ADDR_W-1:0]          req_addr0,
  input  logic [ADDR_W-1:0]          req_addr1,
  input  logic [DATA_W-1:0]          req_wdata0,
  input  logic [DATA_W-1:0]          req_wdata1,
  input  logic [TAG_W-1:0]           req_tag0,
  input  logic [TAG_W-1:0]           req_tag1,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [$clog2(DEPTH)-1:0]   mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_lane,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       rsp_isst,
  output logic                       rsp_err,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [15:0]                conflict_cnt
);

  localparam int unsigned MA_W = $clog2(DEPTH);

  typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_e;

  state_e              state_q, state_d;

  // Response register: at most one response outstanding
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_lane_q, rsp_lane_d;
  logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
  logic                rsp_isst_q, rsp_isst_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_ld_q, rsp_ld_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                can_issue;
  logic                gnt0, gnt1, gnt_any;

  // Fields of the candidate request (lane 0 if valid, otherwise lane 1)
  logic                sel_isld, sel_isst;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [TAG_W-1:0]    sel_tag;
  logic                sel_noop, sel_bad, sel_acc;

  // Candidate selection and legality decode
  always_comb begin
    sel_isld  = req_valid0 ? req_isld0  : req_isld1;
    sel_isst  = req_valid0 ? req_isst0  : req_isst1;
    sel_addr  = req_valid0 ? req_addr0  : req_addr1;
    sel_wdata = req_valid0 ? req_wdata0 : req_wdata1;
    sel_tag   = req_valid0 ? req_tag0   : req_tag1;
    sel_noop  = !sel_isld && !sel_isst;
    sel_bad   = (sel_isld && sel_isst) || (32'(sel_addr) >= 32'(DEPTH));
    sel_acc   = !sel_noop && !sel_bad;
  end

  // FSM next state, grant and memory issue
  always_comb begin
    state_d    = state_q;
    can_issue  = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    gnt_any    = 1'b0;
    req_ready0 = 1'b0;
    req_ready1 = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      ST_RUN: begin
        if (rsp_valid_q && !rsp_ready) begin
          state_d = ST_HOLD;
        end else begin
          can_issue = 1'b1;
        end
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          state_d   = ST_RUN;
          can_issue = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (reset) begin
      can_issue = 1'b0;
    end

    gnt0       = can_issue && req_valid0;
    gnt1       = can_issue && !req_valid0 && req_valid1;
    gnt_any    = gnt0 || gnt1;
    req_ready0 = gnt0;
    req_ready1 = gnt1;

    // Illegal requests and no-ops are consumed without touching memory
    if (gnt_any && sel_acc) begin
      mem_en   = 1'b1;
      mem_we   = sel_isst;
      mem_addr = sel_addr[MA_W-1:0];
      if (sel_isst) begin
        mem_wdata = sel_wdata;
      end
    end
  end

  // Response register next state and hold-data capture
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_lane_d  = rsp_lane_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_isst_d  = rsp_isst_q;
    rsp_err_d   = rsp_err_q;
    rsp_ld_d    = rsp_ld_q;
    hold_d      = hold_q;

    // The slot frees when empty or when the pending response is taken
    if (!rsp_valid_q || rsp_ready) begin
      rsp_valid_d = gnt_any && !sel_noop;
      rsp_lane_d  = gnt1;
      rsp_tag_d   = sel_tag;
      rsp_isst_d  = sel_isst;
      rsp_err_d   = sel_bad;
      rsp_ld_d    = sel_acc && sel_isld;
    end

    // Read data is only valid for one cycle, so keep a copy while stalled
    if (state_q == ST_RUN && state_d == ST_HOLD) begin
      hold_d = mem_rdata;
    end
  end

  // Saturating conflict counter
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_RUN && req_valid0 && req_valid1 && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      rsp_valid_q <= 1'b0;
      rsp_lane_q  <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_isst_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_ld_q    <= 1'b0;
      hold_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_lane_q  <= rsp_lane_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_isst_q  <= rsp_isst_d;
      rsp_err_q   <= rsp_err_d;
      rsp_ld_q    <= rsp_ld_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
    end
  end

  // Response outputs; load data comes straight from memory unless stalled
  always_comb begin
    rsp_valid    = rsp_valid_q;
    rsp_lane     = rsp_lane_q;
    rsp_tag      = rsp_tag_q;
    rsp_isst     = rsp_isst_q;
    rsp_err      = rsp_err_q;
    conflict_cnt = cnt_q;
    rsp_data     = '0;
    if (rsp_valid_q && rsp_ld_q) begin
      rsp_data = (state_q == ST_HOLD) ? hold_q : mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized self-checking bench for dmem_port_arbiter with a transaction
// level reference model (expected-response queue plus reference memory).
module tb_dmem_port_arbiter;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned TAG_W  = 3;

  typedef struct packed {
    logic        valid;
    logic        isld;
    logic        isst;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [2:0]  tag;
  } req_t;

  typedef struct packed {
    logic        lane;
    logic [2:0]  tag;
    logic        isst;
    logic        err;
    logic [15:0] data;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid0, req_valid1, req_ready0, req_ready1;
  logic        req_isld0, req_isld1, req_isst0, req_isst1;
  logic [15:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [2:0]  req_tag0, req_tag1;
  logic        mem_en, mem_we;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        rsp_valid, rsp_ready, rsp_lane, rsp_isst, rsp_err;
  logic [2:0]  rsp_tag;
  logic [15:0] rsp_data, conflict_cnt;

  dmem_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_isld0(req_isld0), .req_isld1(req_isld1),
    .req_isst0(req_isst0), .req_isst1(req_isst1),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_tag0(req_tag0), .req_tag1(req_tag1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lane(rsp_lane),
    .rsp_tag(rsp_tag), .rsp_isst(rsp_isst), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .conflict_cnt(conflict_cnt)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'(32'h1357 * i + 32'h00A5);
  endfunction

  // Synchronous-read memory; returns junk whenever no read was issued
  logic [15:0] ram [DEPTH];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] <= init_val(i);
      mem_rdata <= 16'h0;
    end else begin
      mem_rdata <= 16'($urandom);
      if (mem_en) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else        mem_rdata     <= ram[mem_addr];
      end
    end
  end

  // Reference model state
  rsp_t        exp_q[$];
  logic [15:0] ref_mem [DEPTH];
  bit          model_hold;
  int          exp_cnt;
  req_t        l0, l1;
  logic        rdy, rst;
  int          n_tests, n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic v, input logic ld, input logic st,
                              input logic [15:0] a, input logic [15:0] d, input logic [2:0] t);
    req_t r;
    r.valid = v; r.isld = ld; r.isst = st; r.addr = a; r.wdata = d; r.tag = t;
    return r;
  endfunction

  // mode 0: idle, 1: random, 2: always valid
  function automatic req_t gen(input int mode);
    req_t r;
    int   k;
    r = '0;
    if (mode == 0) return r;
    r.valid = (mode == 2) || ($urandom_range(0, 9) < 7);
    k = int'($urandom_range(0, 15));
    r.isld = (k < 6) || (k == 12) || (k == 13);
    r.isst = (k >= 6 && k < 14);
    r.addr = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(32, 65535))
                                         : 16'($urandom_range(0, 7));
    r.wdata = 16'($urandom);
    r.tag   = 3'($urandom);
    return r;
  endfunction

  task automatic apply();
    reset      = rst;
    rsp_ready  = rdy;
    req_valid0 = l0.valid; req_isld0 = l0.isld; req_isst0 = l0.isst;
    req_addr0  = l0.addr;  req_wdata0 = l0.wdata; req_tag0 = l0.tag;
    req_valid1 = l1.valid; req_isld1 = l1.isld; req_isst1 = l1.isst;
    req_addr1  = l1.addr;  req_wdata1 = l1.wdata; req_tag1 = l1.tag;
  endtask

  // One cycle: check outputs at negedge, advance model at posedge, drive next inputs
  task automatic step(input int mode);
    rsp_t e;
    req_t s;
    logic pend, can, g0, g1, noop, bad, acc;
    @(negedge clk);
    pend = (exp_q.size() != 0);
    can  = !rst && (!pend || rdy);
    g0   = can && l0.valid;
    g1   = can && !l0.valid && l1.valid;
    s    = l0.valid ? l0 : l1;
    noop = !s.isld && !s.isst;
    bad  = (s.isld && s.isst) || (s.addr >= 16'(DEPTH));
    acc  = !noop && !bad;

    check_eq("req_ready0", 32'(req_ready0), 32'(g0));
    check_eq("req_ready1", 32'(req_ready1), 32'(g1));
    check_eq("mem_en", 32'(mem_en), 32'((g0 || g1) && acc));
    if ((g0 || g1) && acc) begin
      check_eq("mem_we", 32'(mem_we), 32'(s.isst));
      check_eq("mem_addr", 32'(mem_addr), 32'(s.addr[4:0]));
      if (s.isst) check_eq("mem_wdata", 32'(mem_wdata), 32'(s.wdata));
    end
    check_eq("rsp_valid", 32'(rsp_valid), 32'(pend));
    if (pend) begin
      e = exp_q[0];
      check_eq("rsp_lane", 32'(rsp_lane), 32'(e.lane));
      check_eq("rsp_tag", 32'(rsp_tag), 32'(e.tag));
      check_eq("rsp_isst", 32'(rsp_isst), 32'(e.isst));
      check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
      check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
    end
    check_eq("conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt));

    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      model_hold = 1'b0;
      exp_cnt    = 0;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_val(i);
    end else begin
      if (!model_hold && l0.valid && l1.valid && exp_cnt < 65535) exp_cnt++;
      if (pend && rdy) void'(exp_q.pop_front());
      model_hold = pend && !rdy;
      if (g0 || g1) begin
        if (!noop) begin
          e.lane = g1;
          e.tag  = s.tag;
          e.isst = s.isst;
          e.err  = bad;
          e.data = (acc && s.isld) ? ref_mem[s.addr[4:0]] : 16'h0;
          exp_q.push_back(e);
        end
        if (acc && s.isst) ref_mem[s.addr[4:0]] = s.wdata;
        if (g0) l0 = gen(mode);
        else    l1 = gen(mode);
      end
    end
    if (!l0.valid) l0 = gen(mode);
    if (!l1.valid) l1 = gen(mode);
    if (mode == 1) begin
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
    end else if (mode == 2) begin
      rdy = 1'b1;
      rst = 1'b0;
    end
    #1;
    apply();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    model_hold = 1'b0; exp_cnt = 0;
    l0 = '0; l1 = '0; rdy = 1'b1; rst = 1'b1;
    apply();
    repeat (2) @(posedge clk);
    #1;
    step(0);                                   // reset state
    rst = 1'b0; apply();

    // Store BEEF to 5 on lane 0, then load 5 on lane 1
    l0 = mk(1, 0, 1, 16'd5, 16'hBEEF, 3'd2);
    l1 = mk(1, 1, 0, 16'd5, 16'h0, 3'd6);
    apply();
    repeat (4) step(0);

    // Conflicting loads, then back-pressure for three cycles
    l0 = mk(1, 1, 0, 16'd7, 16'h0, 3'd1);
    l1 = mk(1, 1, 0, 16'd3, 16'h0, 3'd4);
    apply(); step(0);
    rdy = 1'b0; apply(); repeat (3) step(0);
    rdy = 1'b1; apply(); repeat (3) step(0);

    // Out-of-range address and isld&&isst
    l0 = mk(1, 1, 0, 16'h0020, 16'h0, 3'd5); apply(); step(0);
    l0 = mk(1, 1, 1, 16'd1, 16'h1234, 3'd3); apply(); repeat (3) step(0);

    // Reset while a response is held
    l0 = mk(1, 1, 0, 16'd9, 16'h0, 3'd7); apply(); step(0);
    rdy = 1'b0; apply(); repeat (2) step(0);
    rst = 1'b1; apply(); step(0);
    rst = 1'b0; rdy = 1'b1; apply(); repeat (3) step(0);

    repeat (3000) step(1);

    // Both lanes valid long enough to saturate the conflict counter
    rst = 1'b0; rdy = 1'b1; apply();
    repeat (66000) step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
